pbit_vote_decoder: RTL

Downstream consumer of the invertible ripple adder's stochastic p-bit outputs. It discards a programmable burn-in period, then counts the ones on every p-bit over a programmable number of sampling cycles. It majority-decodes each bit into a deterministic A/B/S/overflow result and flags whether that result is arithmetically consistent. It replaces the averaging done ad hoc in benches and gives the host a single valid-qualified answer per run.

---
 rtl/pbit_vote_decoder_pkg.sv | 30 +++
 rtl/pbit_ones_counter.sv | 41 ++++
 rtl/pbit_vote_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pbit_vote_decoder_pkg.sv
// ============================================================================
//  Module      : pbit_vote_decoder_pkg
//  Description : Shared state encoding, readout selects and default widths
//                for the p-bit vote decoder and the adder top level.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pbit_vote_decoder_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_BURN_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURN  = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Base codes of the cnt_sel groups; bit i of a group is base + i.
   localparam logic [3:0] SEL_A0  = 4'd0;
   localparam logic [3:0] SEL_B0  = 4'd4;
   localparam logic [3:0] SEL_S0  = 4'd8;
   localparam logic [3:0] SEL_OVF = 4'd12;

endpackage

`default_nettype wire

// File: rtl/pbit_ones_counter.sv
// ============================================================================
//  Module      : pbit_ones_counter
//  Description : Ones counter for one p-bit plus its strict-majority compare.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pbit_ones_counter
   import pbit_vote_decoder_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_bit,
   input  logic [CNT_W-1:0] i_num_steps,
   output logic [CNT_W-1:0] o_count,
   output logic             o_majority
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && i_bit) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // One extra bit so 2*count cannot wrap; a tie resolves to 0.
   assign o_majority = ({r_count, 1'b0} > {1'b0, i_num_steps});
   assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/pbit_vote_decoder.sv
// ============================================================================
//  Module      : pbit_vote_decoder
//  Description : Burn-in, ones counting and majority decode of the adder's
//                p-bit outputs, with an arithmetic consistency flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pbit_vote_decoder
   import pbit_vote_decoder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int BURN_W = DEF_BURN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  a_out,
   input  logic [WIDTH-1:0]  b_out,
   input  logic [WIDTH-1:0]  sum_out,
   input  logic              overflow,
   input  logic              start,
   input  logic              abort,
   input  logic [BURN_W-1:0] burn_in,
   input  logic [CNT_W-1:0]  num_steps,
   input  logic [3:0]        cnt_sel,
   output logic              busy,
   output logic              valid,
   output logic [WIDTH-1:0]  a_dec,
   output logic [WIDTH-1:0]  b_dec,
   output logic [WIDTH-1:0]  sum_dec,
   output logic              ovf_dec,
   output logic              consistent,
   output logic [CNT_W-1:0]  cnt_out
);

   localparam int c_NBITS = 3*WIDTH + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BURN_W-1:0]   r_burn_cnt;
   logic [CNT_W-1:0]    r_num_steps;
   logic [CNT_W-1:0]    r_step_cnt;
   logic [c_NBITS-1:0]  r_dec;
   logic                r_consistent;

   logic                w_start_run;
   logic                w_count_en;
   logic                w_enter_done;
   logic                w_n_zero;
   logic [c_NBITS-1:0]  w_bits;
   logic [c_NBITS-1:0]  w_maj;
   logic [CNT_W-1:0]    w_cnt [c_NBITS];
   logic [WIDTH:0]      w_ab_sum;
   logic                w_consistent;
   logic [CNT_W-1:0]    w_cnt_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start_run  = 1'b0;
      w_count_en   = 1'b0;
      w_enter_done = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w_start_run = 1'b1;
                  if (burn_in != '0)        w_state_nxt = ST_BURN;
                  else if (num_steps != '0) w_state_nxt = ST_ACCUM;
                  else begin
                     w_state_nxt  = ST_DONE;
                     w_enter_done = 1'b1;
                  end
               end
            end
            ST_BURN: begin
               if (r_burn_cnt == BURN_W'(1)) begin
                  if (r_num_steps == '0) begin
                     w_state_nxt  = ST_DONE;
                     w_enter_done = 1'b1;
                  end else begin
                     w_state_nxt = ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               // One extra cycle after the last sample lets the decode see final counts.
               if (r_step_cnt == r_num_steps) begin
                  w_state_nxt  = ST_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_count_en = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_n_zero = w_start_run ? (num_steps == '0) : (r_num_steps == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_burn_cnt   <= '0;
         r_num_steps  <= '0;
         r_step_cnt   <= '0;
         r_dec        <= '0;
         r_consistent <= 1'b0;
      end else begin
         if (w_start_run) begin
            r_burn_cnt  <= burn_in;
            r_num_steps <= num_steps;
            r_step_cnt  <= '0;
         end else begin
            if (r_state == ST_BURN) r_burn_cnt <= r_burn_cnt - BURN_W'(1);
            if (w_count_en)         r_step_cnt <= r_step_cnt + CNT_W'(1);
         end
         if (w_enter_done) begin
            if (w_n_zero) begin
               r_dec        <= '0;
               r_consistent <= 1'b1;
            end else begin
               r_dec        <= w_maj;
               r_consistent <= w_consistent;
            end
         end
      end
   end

   assign w_bits = {overflow, sum_out, b_out, a_out};

   generate
      for (genvar j = 0; j < c_NBITS; j++) begin : g_cnt
         pbit_ones_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .i_clr       (w_start_run),
            .i_en        (w_count_en),
            .i_bit       (w_bits[j]),
            .i_num_steps (r_num_steps),
            .o_count     (w_cnt[j]),
            .o_majority  (w_maj[j])
         );
      end
   endgenerate

   assign w_ab_sum     = {1'b0, w_maj[WIDTH-1:0]} + {1'b0, w_maj[2*WIDTH-1:WIDTH]};
   assign w_consistent = (w_maj[3*WIDTH:2*WIDTH] == w_ab_sum);

   always_comb begin
      w_cnt_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt_sel == SEL_A0 + 4'(i)) w_cnt_out = w_cnt[i];
         if (cnt_sel == SEL_B0 + 4'(i)) w_cnt_out = w_cnt[WIDTH+i];
         if (cnt_sel == SEL_S0 + 4'(i)) w_cnt_out = w_cnt[2*WIDTH+i];
      end
      if (cnt_sel == SEL_OVF) w_cnt_out = w_cnt[3*WIDTH];
   end

   assign cnt_out    = w_cnt_out;
   assign busy       = (r_state == ST_BURN) || (r_state == ST_ACCUM);
   assign valid      = (r_state == ST_DONE);
   assign a_dec      = r_dec[WIDTH-1:0];
   assign b_dec      = r_dec[2*WIDTH-1:WIDTH];
   assign sum_dec    = r_dec[3*WIDTH-1:2*WIDTH];
   assign ovf_dec    = r_dec[3*WIDTH];
   assign consistent = r_consistent;

endmodule

`default_nettype wire
